// File: rtl/spi_flash_read_controller.sv
// rtl/spi_flash_read_controller.sv - MMU storage responder serving word reads from SPI flash (READ 0x03)
module spi_flash_read_controller #(
    parameter int          CLK_DIV     = 2,
    parameter logic [31:0] ADDR_OFFSET = 32'h0000_2000,
    parameter int          CS_GAP      = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        memory_access,
    input  logic        memory_is_writing,
    input  logic [31:0] addr,
    input  logic [3:0]  mem_be,
    output logic [31:0] d_out,
    output logic        out_valid,
    output logic        out_err,
    output logic        busy,
    output logic        external_storage_spi_cs_n,
    output logic        external_storage_spi_sck,
    output logic        external_storage_spi_mosi,
    input  logic        external_storage_spi_miso
);

    localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int GAP_W = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(CS_GAP - 1);

    typedef enum logic [2:0] {IDLE, SHIFT, DONE, GAP, ERR} state_t;

    state_t           state;
    logic [DIV_W-1:0] div_cnt;
    logic [GAP_W-1:0] gap_cnt;
    logic [5:0]       bit_cnt;
    logic [31:0]      tx_sr;
    logic [31:0]      rx_sr;
    logic [3:0]       be_q;

    logic [31:0] off;
    logic [23:0] flash_addr;
    logic        req_bad;
    logic [31:0] rx_word;

    // Window offset, word-aligned flash address and the accept-time error decision
    assign off        = addr - ADDR_OFFSET;
    assign flash_addr = off[23:0] & 24'hFF_FFFC;
    assign req_bad    = memory_is_writing || (addr < ADDR_OFFSET) || (off[31:24] != 8'h00);

    // Wire order is byte0 first; present it little-endian with disabled lanes zeroed
    assign rx_word = {rx_sr[7:0]   & {8{be_q[3]}},
                      rx_sr[15:8]  & {8{be_q[2]}},
                      rx_sr[23:16] & {8{be_q[1]}},
                      rx_sr[31:24] & {8{be_q[0]}}};

    // Transaction FSM with SCK generation, command shift-out and data shift-in
    always_ff @(posedge clk) begin
        if (rst) begin
            state                     <= IDLE;
            div_cnt                   <= '0;
            gap_cnt                   <= '0;
            bit_cnt                   <= '0;
            tx_sr                     <= '0;
            rx_sr                     <= '0;
            be_q                      <= '0;
            d_out                     <= '0;
            out_valid                 <= 1'b0;
            out_err                   <= 1'b0;
            busy                      <= 1'b0;
            external_storage_spi_cs_n <= 1'b1;
            external_storage_spi_sck  <= 1'b0;
            external_storage_spi_mosi <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            out_err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (memory_access) begin
                        be_q <= mem_be;
                        busy <= 1'b1;
                        if (req_bad) begin
                            state   <= ERR;
                            out_err <= 1'b1;
                        end else begin
                            state                     <= SHIFT;
                            external_storage_spi_cs_n <= 1'b0;
                            external_storage_spi_sck  <= 1'b0;
                            div_cnt                   <= '0;
                            bit_cnt                   <= '0;
                            tx_sr                     <= {8'h03, flash_addr};
                            external_storage_spi_mosi <= 1'b0;
                            rx_sr                     <= '0;
                        end
                    end
                end
                SHIFT: begin
                    if (div_cnt == DIV_LAST) begin
                        div_cnt                  <= '0;
                        external_storage_spi_sck <= ~external_storage_spi_sck;
                        if (!external_storage_spi_sck) begin
                            // Rising SCK: capture flash data during the last 32 periods
                            if (bit_cnt[5]) begin
                                rx_sr <= {rx_sr[30:0], external_storage_spi_miso};
                            end
                        end else if (bit_cnt == 6'd63) begin
                            state                     <= DONE;
                            external_storage_spi_cs_n <= 1'b1;
                            external_storage_spi_mosi <= 1'b0;
                            out_valid                 <= 1'b1;
                            d_out                     <= rx_word;
                        end else begin
                            // Falling SCK: advance to the next outgoing bit
                            bit_cnt                   <= bit_cnt + 6'd1;
                            external_storage_spi_mosi <= tx_sr[30];
                            tx_sr                     <= {tx_sr[30:0], 1'b0};
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                DONE: begin
                    state   <= GAP;
                    d_out   <= '0;
                    gap_cnt <= '0;
                end
                GAP: begin
                    if (gap_cnt == GAP_LAST) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt + 1'b1;
                    end
                end
                ERR: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_spi_flash_read_controller.sv
// tb/tb_spi_flash_read_controller.sv - self-checking bench for spi_flash_read_controller
module tb_spi_flash_read_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [3:0]  be = '0;
    logic        sel = 1'b0;

    logic [31:0] d0, d1;
    logic        v0, v1, e0, e1, b0, b1, cs0, cs1, sck0, sck1, mosi0, mosi1;
    logic        miso0 = 1'b0;
    logic        miso1 = 1'b0;

    int          errors = 0;
    int          checks = 0;
    int          both_pulse = 0;
    logic [31:0] flash_word = 32'hEFBE_ADDE;

    int          rise0 = 0, rise1 = 0;
    logic [31:0] cap0 = '0, cap1 = '0;

    always #5 clk = ~clk;

    spi_flash_read_controller #(.CLK_DIV(2), .ADDR_OFFSET(32'h0000_2000), .CS_GAP(2)) dut0 (
        .clk(clk), .rst(rst), .memory_access(req && !sel), .memory_is_writing(wr),
        .addr(addr), .mem_be(be), .d_out(d0), .out_valid(v0), .out_err(e0), .busy(b0),
        .external_storage_spi_cs_n(cs0), .external_storage_spi_sck(sck0),
        .external_storage_spi_mosi(mosi0), .external_storage_spi_miso(miso0));

    spi_flash_read_controller #(.CLK_DIV(1), .ADDR_OFFSET(32'h0000_2000), .CS_GAP(2)) dut1 (
        .clk(clk), .rst(rst), .memory_access(req && sel), .memory_is_writing(wr),
        .addr(addr), .mem_be(be), .d_out(d1), .out_valid(v1), .out_err(e1), .busy(b1),
        .external_storage_spi_cs_n(cs1), .external_storage_spi_sck(sck1),
        .external_storage_spi_mosi(mosi1), .external_storage_spi_miso(miso1));

    // Flash models: capture command/address on rising SCK, drive data after falling SCK
    always @(negedge cs0) begin rise0 = 0; cap0 = '0; miso0 = 1'b0; end
    always @(posedge sck0) if (!cs0) begin
        if (rise0 < 32) cap0 = {cap0[30:0], mosi0};
        rise0++;
    end
    always @(negedge sck0) if (!cs0 && rise0 >= 32 && rise0 < 64) miso0 = flash_word[63 - rise0];

    always @(negedge cs1) begin rise1 = 0; cap1 = '0; miso1 = 1'b0; end
    always @(posedge sck1) if (!cs1) begin
        if (rise1 < 32) cap1 = {cap1[30:0], mosi1};
        rise1++;
    end
    always @(negedge sck1) if (!cs1 && rise1 >= 32 && rise1 < 64) miso1 = flash_word[63 - rise1];

    logic [31:0] d_m;
    logic        v_m, e_m, b_m, cs_m, sck_m, mosi_m;
    int          rise_m;
    logic [31:0] cap_m;
    always_comb begin
        d_m    = sel ? d1 : d0;
        v_m    = sel ? v1 : v0;
        e_m    = sel ? e1 : e0;
        b_m    = sel ? b1 : b0;
        cs_m   = sel ? cs1 : cs0;
        sck_m  = sel ? sck1 : sck0;
        mosi_m = sel ? mosi1 : mosi0;
        rise_m = sel ? rise1 : rise0;
        cap_m  = sel ? cap1 : cap0;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    int          p_cyc;
    logic        p_valid, p_err, p_cs, p_sck, cs_low_seen;
    logic [31:0] p_data;
    int          sck_stall;

    // Watch up to max_cyc cycles (cycle numbers relative to the current negedge) for a pulse
    task automatic wait_pulse(input int max_cyc, input bit keep_req);
        logic prev_sck;
        p_cyc = -1; p_valid = 0; p_err = 0; p_data = '0; p_cs = 0; p_sck = 0;
        cs_low_seen = 0; sck_stall = 0; prev_sck = sck_m;
        for (int k = 1; k <= max_cyc; k++) begin
            @(negedge clk);
            if (!cs_m) cs_low_seen = 1;
            if (k >= 2 && !cs_m && sck_m == prev_sck) sck_stall++;
            prev_sck = sck_m;
            if (v_m && e_m) both_pulse++;
            if (v_m || e_m) begin
                p_cyc = k; p_valid = v_m; p_err = e_m; p_data = d_m; p_cs = cs_m; p_sck = sck_m;
                break;
            end
        end
        if (!keep_req || p_cyc < 0) req = 1'b0;
    endtask

    task automatic start_txn(input logic [31:0] a, input logic [3:0] m, input logic w);
        @(negedge clk);
        addr = a; be = m; wr = w; req = 1'b1;
    endtask

    task automatic after_pulse_and_idle(input string tag);
        int n;
        @(negedge clk);
        check({tag, "_next_valid"}, {31'd0, v_m}, 32'd0);
        check({tag, "_next_err"}, {31'd0, e_m}, 32'd0);
        check({tag, "_next_dout"}, d_m, 32'd0);
        n = 0;
        while (b_m && n < 20) begin @(negedge clk); n++; end
        check({tag, "_idle"}, {31'd0, b_m}, 32'd0);
    endtask

    typedef struct {
        logic [31:0] a;
        logic [3:0]  m;
        logic        w;
        logic        exp_err;
        logic [31:0] exp_data;
        logic [23:0] exp_fa;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int gapc, n, vcount;

        vecs[0] = '{32'h0000_2000, 4'hF,    1'b0, 1'b0, 32'hDEAD_BEEF, 24'h000000};
        vecs[1] = '{32'h0000_2006, 4'b0011, 1'b0, 1'b0, 32'h0000_BEEF, 24'h000004};
        vecs[2] = '{32'h0000_3000, 4'hF,    1'b1, 1'b1, 32'h0,         24'h0};
        vecs[3] = '{32'h0000_1000, 4'hF,    1'b0, 1'b1, 32'h0,         24'h0};
        vecs[4] = '{32'h0100_1FFC, 4'hF,    1'b0, 1'b0, 32'hDEAD_BEEF, 24'hFFFFFC};
        vecs[5] = '{32'h0100_2000, 4'hF,    1'b0, 1'b1, 32'h0,         24'h0};
        vecs[6] = '{32'h0000_2010, 4'b1010, 1'b0, 1'b0, 32'hDE00_BE00, 24'h000010};
        vecs[7] = '{32'h0000_1FFF, 4'hF,    1'b0, 1'b1, 32'h0,         24'h0};

        repeat (3) @(negedge clk);
        check("rst_cs_n", {31'd0, cs_m}, 32'd1);
        check("rst_sck", {31'd0, sck_m}, 32'd0);
        check("rst_mosi", {31'd0, mosi_m}, 32'd0);
        check("rst_dout", d_m, 32'd0);
        check("rst_valid", {31'd0, v_m}, 32'd0);
        check("rst_err", {31'd0, e_m}, 32'd0);
        check("rst_busy", {31'd0, b_m}, 32'd0);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            start_txn(vecs[i].a, vecs[i].m, vecs[i].w);
            wait_pulse(400, 1'b0);
            if (vecs[i].exp_err) begin
                check($sformatf("v%0d_err_cycle", i), p_cyc, 32'd1);
                check($sformatf("v%0d_err_flag", i), {31'd0, p_err}, 32'd1);
                check($sformatf("v%0d_no_cs", i), {31'd0, cs_low_seen}, 32'd0);
            end else begin
                check($sformatf("v%0d_valid_cycle", i), p_cyc, 32'd257);
                check($sformatf("v%0d_valid_flag", i), {31'd0, p_valid}, 32'd1);
                check($sformatf("v%0d_dout", i), p_data, vecs[i].exp_data);
                check($sformatf("v%0d_mosi_cmd_addr", i), cap_m, {8'h03, vecs[i].exp_fa});
                check($sformatf("v%0d_sck_rises", i), rise_m, 32'd64);
                check($sformatf("v%0d_cs_at_done", i), {31'd0, p_cs}, 32'd1);
                check($sformatf("v%0d_sck_at_done", i), {31'd0, p_sck}, 32'd0);
            end
            after_pulse_and_idle($sformatf("v%0d", i));
        end

        // Back-to-back: request held high through DONE/GAP with a new address
        start_txn(32'h0000_2000, 4'hF, 1'b0);
        wait_pulse(400, 1'b1);
        check("b2b_first_cycle", p_cyc, 32'd257);
        check("b2b_first_dout", p_data, 32'hDEAD_BEEF);
        addr = 32'h0000_2004;
        gapc = 0; n = 0;
        @(negedge clk);
        check("b2b_next_valid", {31'd0, v_m}, 32'd0);
        while (cs_m && n < 20) begin
            if (b_m) gapc++;
            @(negedge clk); n++;
        end
        check("b2b_gap_cycles", gapc, 32'd2);
        check("b2b_cs_fell", {31'd0, cs_m}, 32'd0);
        wait_pulse(400, 1'b0);
        check("b2b_second_cycle", p_cyc, 32'd256);
        check("b2b_second_addr", cap_m, 32'h0300_0004);
        check("b2b_second_dout", p_data, 32'hDEAD_BEEF);
        after_pulse_and_idle("b2b");

        // Reset in the middle of a read
        start_txn(32'h0000_2000, 4'hF, 1'b0);
        repeat (100) @(negedge clk);
        rst = 1'b1; req = 1'b0;
        @(negedge clk);
        check("mid_rst_cs_n", {31'd0, cs_m}, 32'd1);
        check("mid_rst_sck", {31'd0, sck_m}, 32'd0);
        check("mid_rst_busy", {31'd0, b_m}, 32'd0);
        check("mid_rst_valid", {31'd0, v_m}, 32'd0);
        rst = 1'b0;
        vcount = 0;
        repeat (300) begin @(negedge clk); if (v_m) vcount++; end
        check("mid_rst_no_valid", vcount, 32'd0);
        start_txn(32'h0000_2000, 4'hF, 1'b0);
        wait_pulse(400, 1'b0);
        check("post_rst_cycle", p_cyc, 32'd257);
        check("post_rst_dout", p_data, 32'hDEAD_BEEF);
        after_pulse_and_idle("post_rst");

        // CLK_DIV=1 instance
        sel = 1'b1;
        start_txn(32'h0000_2000, 4'hF, 1'b0);
        wait_pulse(400, 1'b0);
        check("div1_cycle", p_cyc, 32'd129);
        check("div1_dout", p_data, 32'hDEAD_BEEF);
        check("div1_mosi_cmd_addr", cap_m, 32'h0300_0000);
        check("div1_sck_rises", rise_m, 32'd64);
        check("div1_sck_toggle", sck_stall, 32'd0);
        after_pulse_and_idle("div1");

        check("valid_err_exclusive", both_pulse, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
